// File: rtl/counter_cmd_seq.sv
// counter_cmd_seq
// ---------------
// Command sequencer that sits directly upstream of an up/down counter.
// Commands {op, arg} arrive over a valid/ready interface, are buffered in a
// small FIFO and replayed one at a time onto the counter's control inputs.
//
// Opcodes: 00 LOAD  (one cycle of load_n=0, data_load=arg)
//          01 UP    (arg cycles of ce=1, up_down=1)
//          10 DOWN  (arg cycles of ce=1, up_down=0)
//          11 HOLD  (arg cycles of ce=0)
// A zero-count UP/DOWN/HOLD completes without touching the counter.
//
// Handshake: a command is transferred on every rising clk edge where
// cmd_valid && cmd_ready are both high; cmd_ready depends only on FIFO
// fullness (never on cmd_valid) and is low while in reset.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake
//   cmd_op, cmd_arg     opcode and load value / cycle count
//   max_count, zero     counter flags (counter at all-ones / at zero)
//   load_n, ce, up_down, data_load   counter control outputs
//   busy                FIFO non-empty or a command executing
//   done                one-cycle pulse per completed command
//   sat_hit             one-cycle pulse when a count is cut short at a boundary
//
// Build option: define COUNTER_CMD_SEQ_SAT_STOP_EN to stop counting at the
// counter's boundary (ce gated by max_count/zero) instead of wrapping.

module counter_cmd_seq #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             max_count,
    input  logic             zero,
    output logic             load_n,
    output logic             ce,
    output logic             up_down,
    output logic [WIDTH-1:0] data_load,
    output logic             busy,
    output logic             done,
    output logic             sat_hit
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Command FIFO: pointers carry one extra wrap bit so full and empty
    // are distinguishable without a separate counter.
    // ------------------------------------------------------------------
    logic [WIDTH+1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             rdy_en;
    logic [1:0]       head_op;
    logic [WIDTH-1:0] head_arg;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // rdy_en keeps cmd_ready low during reset and rises on the first edge
    // after release.
    assign cmd_ready = rdy_en & ~full;
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state == S_IDLE) & ~empty;

    assign head_op  = mem[rd_ptr[AW-1:0]][WIDTH+1:WIDTH];
    assign head_arg = mem[rd_ptr[AW-1:0]][WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_arg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign busy = (state != S_IDLE) | ~empty;

    // ------------------------------------------------------------------
    // Boundary handling. The flag for the current direction gates ce
    // combinationally so the counter never steps past its limit.
    // ------------------------------------------------------------------
    logic ce_q;
    logic blocked;

`ifdef COUNTER_CMD_SEQ_SAT_STOP_EN
    logic sat_q;
    assign blocked = ce_q & (up_down ? max_count : zero);
    assign ce      = ce_q & ~blocked;
    assign sat_hit = sat_q;
`else
    logic unused_flags;
    assign unused_flags = max_count ^ zero;
    assign blocked      = 1'b0;
    assign ce           = ce_q;
    assign sat_hit      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM. Outputs are registered alongside the state so that a
    // command popped in cycle N drives the counter in cycle N+1.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rem       <= '0;
            ce_q      <= 1'b0;
            load_n    <= 1'b1;
            up_down   <= 1'b1;
            data_load <= '0;
            done      <= 1'b0;
`ifdef COUNTER_CMD_SEQ_SAT_STOP_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        rem <= head_arg;
                        if (head_op == OP_LOAD) begin
                            state     <= S_LOAD;
                            load_n    <= 1'b0;
                            data_load <= head_arg;
                        end else if (head_arg == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (head_op == OP_HOLD) begin
                            state <= S_HOLD;
                        end else begin
                            state   <= S_RUN;
                            ce_q    <= 1'b1;
                            up_down <= (head_op == OP_UP);
                        end
                    end
                end

                S_LOAD: begin
                    load_n <= 1'b1;
                    state  <= S_DONE;
                    done   <= 1'b1;
                end

                S_RUN: begin
                    if (blocked) begin
                        // Boundary reached: abandon the remaining steps.
                        rem   <= '0;
                        ce_q  <= 1'b0;
                        state <= S_DONE;
                        done  <= 1'b1;
`ifdef COUNTER_CMD_SEQ_SAT_STOP_EN
                        sat_q <= 1'b1;
`endif
                    end else if (rem == ONE) begin
                        rem   <= '0;
                        ce_q  <= 1'b0;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        rem <= rem - ONE;
                    end
                end

                S_HOLD: begin
                    if (rem == ONE) begin
                        rem   <= '0;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        rem <= rem - ONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
`ifdef COUNTER_CMD_SEQ_SAT_STOP_EN
                    sat_q <= 1'b0;
`endif
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// tb_counter_cmd_seq
// ------------------
// Directed bench for counter_cmd_seq. A behavioural up/down counter closes
// the loop on load_n/ce/up_down/data_load and drives max_count/zero.
// Each issued command pushes its expected completion record
// {gap, sat, ce cycles, counter value} into exp_q; a monitor pops one record
// per done pulse. gap is the distance in cycles from the previous done pulse
// (0 = not checked, used when the command was not already queued).

module tb_counter_cmd_seq;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             max_count;
  logic             zero;
  logic             load_n;
  logic             ce;
  logic             up_down;
  logic [WIDTH-1:0] data_load;
  logic             busy;
  logic             done;
  logic             sat_hit;

  counter_cmd_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .max_count (max_count),
    .zero      (zero),
    .load_n    (load_n),
    .ce        (ce),
    .up_down   (up_down),
    .data_load (data_load),
    .busy      (busy),
    .done      (done),
    .sat_hit   (sat_hit)
  );

  // ---------------- clock / cycle count / counter model ----------------
  int cyc = 0;
  logic [WIDTH-1:0] cnt = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  always @(posedge clk) begin
    if (!load_n) cnt <= data_load;
    else if (ce) cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
  end

  assign max_count = (cnt == 4'hF);
  assign zero      = (cnt == 4'h0);

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  int acc_cyc = 0;

  function automatic logic [15:0] pack(int gap, bit sat, int cen, logic [3:0] cv);
    return {gap[5:0], sat, cen[4:0], cv};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    int ce_seen;
    bit sat_seen;
    int last_done;
    logic [15:0] e;
    logic [15:0] a;
    ce_seen = 0;
    sat_seen = 0;
    last_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ce_seen = 0;
        sat_seen = 0;
      end else begin
        if (ce) ce_seen++;
        if (sat_hit) sat_seen = 1;
        if (done) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: done pulse with no command pending (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            a = pack(cyc - last_done, sat_seen, ce_seen, cnt);
            if (e[15:10] == 6'd0) a[15:10] = 6'd0;
            if (a !== e) begin
              n_fail++;
              $display("FAIL done_rec: got gap=%0d sat=%0d ce=%0d cnt=%0h expected gap=%0d sat=%0d ce=%0d cnt=%0h (cycle %0d)",
                       a[15:10], a[9], a[8:4], a[3:0], e[15:10], e[9], e[8:4], e[3:0], cyc);
            end
          end
          last_done = cyc;
          ce_seen = 0;
          sat_seen = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(logic [1:0] op, logic [3:0] arg, int gap, bit sat, int cen, logic [3:0] cv);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    t = 0;
    while (!cmd_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: cmd_ready stuck at 0 for op %0d arg %0d", op, arg);
      cmd_valid = 1'b0;
    end else begin
      exp_q.push_back(pack(gap, sat, cen, cv));
      acc_cyc = cyc;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || exp_q.size() != 0) && t < budget);
    check("idle_reached", {31'd0, busy || exp_q.size() != 0}, 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_load_n"},    {31'd0, load_n},    32'd1);
    check({tag, "_ce"},        {31'd0, ce},        32'd0);
    check({tag, "_up_down"},   {31'd0, up_down},   32'd1);
    check({tag, "_data_load"}, {28'd0, data_load}, 32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_sat_hit"},   {31'd0, sat_hit},   32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int t;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_arg = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // LOAD 5: load strobe exactly in T+2, done in T+3.
    send(2'b00, 4'd5, 0, 0, 0, 4'd5);
    @(negedge clk);
    check("load_t1_load_n", {31'd0, load_n}, 32'd1);
    @(negedge clk);
    check("load_t2_load_n", {31'd0, load_n}, 32'd0);
    check("load_t2_data", {28'd0, data_load}, 32'd5);
    check("load_t2_ce", {31'd0, ce}, 32'd0);
    @(negedge clk);
    check("load_t3_done", {31'd0, done}, 32'd1);
    check("load_t3_load_n", {31'd0, load_n}, 32'd1);
    wait_idle(50);

    // LOAD 3 then UP 4 back-to-back.
    send(2'b00, 4'd3, 0, 0, 0, 4'd3);
    send(2'b01, 4'd4, 6, 0, 4, 4'd7);
    wait_idle(50);

    // DOWN 0 (no counting) then HOLD 3.
    send(2'b10, 4'd0, 0, 0, 0, 4'd7);
    send(2'b11, 4'd3, 5, 0, 0, 4'd7);
    wait_idle(50);

    // Fill the FIFO with HOLD 15 (one entry drains into execution first).
    send(2'b11, 4'd15, 0, 0, 0, 4'd7);
    for (int i = 0; i < DEPTH; i++) send(2'b11, 4'd15, 17, 0, 0, 4'd7);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_arg = 4'd9;
    for (int i = 0; i < 3; i++) begin
      check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    t = 0;
    while (!cmd_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("ready_return_cycle", cyc, acc_cyc + 15);
    wait_idle(200);

    // Boundary: LOAD 14, UP 5, LOAD 3, DOWN 5.
`ifdef COUNTER_CMD_SEQ_SAT_STOP_EN
    send(2'b00, 4'd14, 0, 0, 0, 4'd14);
    send(2'b01, 4'd5, 4, 1, 1, 4'd15);
    send(2'b00, 4'd3, 3, 0, 0, 4'd3);
    send(2'b10, 4'd5, 6, 1, 3, 4'd0);
`else
    send(2'b00, 4'd14, 0, 0, 0, 4'd14);
    send(2'b01, 4'd5, 7, 0, 5, 4'd3);
    send(2'b00, 4'd3, 3, 0, 0, 4'd3);
    send(2'b10, 4'd5, 7, 0, 5, 4'd14);
`endif
    wait_idle(80);

    // Reset in the middle of UP 10: aborted, no done pulse afterwards.
    send(2'b01, 4'd10, 0, 0, 10, 4'd0);
    t = 0;
    while (!ce && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("run_started", {31'd0, ce}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    check("midrst_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Recovery after reset.
    send(2'b00, 4'd2, 0, 0, 0, 4'd2);
    wait_idle(50);

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_cmd_seq.md
Name: counter_cmd_seq

Overview:
- Command sequencer directly upstream of the up/down counter stage.
- Accepts queued commands (load, count up N, count down N, hold N) over a valid/ready interface.
- Buffers commands in a small FIFO and replays each one cycle-accurately onto the counter's control inputs (load_n, ce, up_down, data_load).
- Watches the counter's max_count/zero flags for boundary handling.

Parameters:
- WIDTH, 4: counter and argument width; must equal the counter's WIDTH.
- DEPTH, 4: command FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 HOLD
- cmd_arg  in  WIDTH  load value or step/cycle count
- max_count  in  1  counter at all-ones
- zero  in  1  counter at zero
- load_n  out  1  active-low load to counter
- ce  out  1  count enable to counter
- up_down  out  1  1 = up, 0 = down
- data_load  out  WIDTH  load value to counter
- busy  out  1  FIFO non-empty or command executing
- done  out  1  one-cycle pulse per completed command
- sat_hit  out  1  one-cycle pulse on boundary abort (0 without macro)

Behaviour:
- Reset (async, rst_n=0):
  - FIFO flushed; FSM to IDLE.
  - load_n=1, ce=0, up_down=1, data_load=0, done=0, sat_hit=0, busy=0.
  - cmd_ready=1 once rst_n=1.
  - Reset mid-command aborts it; no done pulse.
- FIFO:
  - Push {op,arg} on cmd_valid&&cmd_ready; cmd_ready = !full.
  - Push and pop in the same cycle are both allowed.
  - When full, cmd_ready=0 and nothing is written.
  - Pop only from IDLE when non-empty.
- FSM states: IDLE, LOAD, RUN, HOLD, DONE. All outputs registered except ce gating (see Optional Feature).
- IDLE:
  - If FIFO non-empty: pop, latch op/arg, set rem=arg.
  - Go to LOAD (op 00); to RUN (01/10) or HOLD (11) if arg≠0; to DONE if arg=0.
- Latency: command accepted in cycle T → first control output active in cycle T+2.
- LOAD: exactly one cycle with load_n=0, data_load=arg, ce=0; then DONE.
- RUN:
  - ce=1, up_down=1 for UP and 0 for DOWN.
  - Exactly arg consecutive cycles, rem decrements each cycle; leave when rem reaches 1→0, then DONE.
  - Without the macro, the counter wraps freely (F→0 up, 0→F down).
- HOLD: ce=0, load_n=1 for arg cycles; then DONE.
- DONE:
  - done=1 for one cycle; ce=0, load_n=1; then IDLE.
  - Back-to-back commands therefore have a two-cycle gap (DONE + IDLE pop).
- up_down and data_load hold their last values outside RUN/LOAD.
- busy = (state≠IDLE) || FIFO non-empty.
- Illegal inputs: none exist; all four opcodes are defined.

Optional Feature:
- Macro: COUNTER_CMD_SEQ_SAT_STOP_EN.
- Defined:
  - In RUN, ce = ce_q & ~(up ? max_count : zero), combinational from the flag.
  - The first RUN cycle where the flag blocks ce aborts the command: rem cleared, sat_hit=1 for one cycle, FSM to DONE (done still pulses).
  - The counter never wraps.
- Not defined: ce = ce_q; sat_hit tied 0; wrap-around permitted.

Test Plan:
- Reset, then LOAD arg=5 at cycle T → load_n=0 and data_load=5 in T+2 only; done in T+3; counter=5.
- LOAD 3, then UP 4 queued back-to-back → ce=1, up_down=1 for exactly 4 cycles; counter=7; two done pulses.
- DOWN 0 → no ce cycles, done pulse two cycles after pop; HOLD 3 → ce=0 for 3 cycles, counter unchanged.
- Fill FIFO with DEPTH HOLD 15 commands → cmd_ready=0; extra cmd_valid ignored; cmd_ready returns 1 on first pop.
- LOAD 14, UP 5:
  - Macro off → counter wraps to 3, sat_hit=0.
  - Macro on → counter stops at 15, sat_hit pulse, done pulse.
- Assert rst_n=0 during RUN of UP 10 → all outputs at reset values immediately; FIFO empty; no done pulse after release.
